// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite write slave: response codes and FSM states.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_MEM     = 2'b01,
        ST_BRESP   = 2'b10
    } state_e;

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// One-entry valid/ready holding register. It accepts a payload whenever it is
// empty and keeps it untouched until the owner retires it with clear_i.
module axi4_lite_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Capture on a handshake into an empty slot; retirement frees the slot.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    // Slot state and payload storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi4_lite_write_slave_decoupled.sv
// AXI4-Lite write slave with independent AW and W holding registers. Once both
// halves of a write are present the address is decoded; legal writes are
// handed to a simple memory port, illegal ones are answered with SLVERR.
module axi4_lite_write_slave_decoupled
    import axi4_lite_pkg::*;
#(
    parameter  int                    ADDR_WIDTH = 32,
    parameter  int                    DATA_WIDTH = 32,
    parameter  logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter  int unsigned           ADDR_SPAN  = 4096,
    localparam int                    STRB_WIDTH = DATA_WIDTH / 8,
    localparam int                    OFFS       = $clog2(STRB_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    output logic                  mem_write,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [STRB_WIDTH-1:0] byte_en,
    output logic [15:0]           err_count
);

    // Upper bound of the window, one bit wider so BASE_ADDR+ADDR_SPAN cannot wrap.
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH + 1)'(ADDR_SPAN);

    state_e                          state_q, state_d;
    resp_e                           bresp_q, bresp_d;
    logic [15:0]                     err_q, err_d;
    logic                            retire;
    logic                            aw_full, w_full;
    logic                            aw_ready, w_ready;
    logic [ADDR_WIDTH-1:0]           aw_addr;
    logic [DATA_WIDTH+STRB_WIDTH-1:0] w_payload;
    logic [DATA_WIDTH-1:0]           w_data;
    logic [STRB_WIDTH-1:0]           w_strb;
    logic                            addr_legal;

    axi4_lite_hold_reg #(
        .WIDTH (ADDR_WIDTH)
    ) u_aw_hold (
        .clk     (clk),
        .rst     (rst),
        .valid_i (S_AXI_AWVALID),
        .ready_o (aw_ready),
        .data_i  (S_AXI_AWADDR),
        .clear_i (retire),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    axi4_lite_hold_reg #(
        .WIDTH (DATA_WIDTH + STRB_WIDTH)
    ) u_w_hold (
        .clk     (clk),
        .rst     (rst),
        .valid_i (S_AXI_WVALID),
        .ready_o (w_ready),
        .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .clear_i (retire),
        .full_o  (w_full),
        .data_o  (w_payload)
    );

    assign w_data = w_payload[DATA_WIDTH-1:0];
    assign w_strb = w_payload[DATA_WIDTH+STRB_WIDTH-1:DATA_WIDTH];

    assign addr_legal = ({1'b0, aw_addr} >= WIN_LO) &&
                        ({1'b0, aw_addr} <  WIN_HI) &&
                        (aw_addr[OFFS-1:0] == '0);

    // Transaction sequencing: decode, memory access, response, with retirement
    // of both holding registers on the edge that leaves the issuing state.
    always_comb begin
        state_d = state_q;
        bresp_d = bresp_q;
        err_d   = err_q;
        retire  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (aw_full && w_full) begin
                    if (addr_legal) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_BRESP;
                        bresp_d = SLVERR;
                        retire  = 1'b1;
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                    end
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_BRESP;
                    bresp_d = OKAY;
                    retire  = 1'b1;
                end
            end
            ST_BRESP: begin
                if (S_AXI_BREADY) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // FSM state, latched response code and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            bresp_q <= OKAY;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
            err_q   <= err_d;
        end
    end

    // READY is forced low while reset is held, even though the slots are empty.
    assign S_AXI_AWREADY = aw_ready && !rst;
    assign S_AXI_WREADY  = w_ready && !rst;

    assign S_AXI_BVALID  = (state_q == ST_BRESP);
    assign S_AXI_BRESP   = S_AXI_BVALID ? bresp_q : OKAY;

    assign mem_write     = (state_q == ST_MEM);
    assign addr          = mem_write ? aw_addr : '0;
    assign write_data    = mem_write ? w_data  : '0;
    assign byte_en       = mem_write ? w_strb  : '0;

    assign err_count     = err_q;

endmodule
